conv_window_gen: RTL and testbench

Sliding-window generator that turns a raster-order pixel stream into the K×K window bus consumed by the convolution calculation stage: the `data2conv`/`en_in` pair. It holds (KERNEL-1) line buffers of IMG_W pixels plus a K×K window register array. It emits one packed window per input pixel once a full window is available, using valid-only (no padding) convolution. It sits between the input pixel source and the conv calculation block. Weights are supplied separately.

---
 rtl/conv_window_gen.sv | 123 ++++++++++++
 tb/tb_conv_window_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Raster pixel stream to packed KERNEL x KERNEL sliding window
//               (valid-only convolution, one window per accepted pixel).
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               pix_in,
    input  logic                       pix_valid,
    input  logic                       sof,
    output logic [KERNEL*KERNEL*N-1:0] win,
    output logic                       win_valid,
    output logic                       eof
);

    localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic               w_complete;
    logic               r_win_valid;
    logic               r_eof;
    logic [N-1:0]       r_win_arr [KERNEL][KERNEL];
    logic [N-1:0]       w_new_col [KERNEL];

    // Position of the pixel being accepted; sof forces it to (0,0).
    assign w_col = sof ? '0 : r_col;
    assign w_row = sof ? '0 : r_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (w_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    assign w_new_col[KERNEL-1] = pix_in;

    generate
        if (KERNEL > 1) begin : g_lb
            localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(KERNEL - 1);
            localparam logic [c_ROW_W-1:0] c_ROW_FIRST = c_ROW_W'(KERNEL - 1);

            // Buffer k holds the row k+1 above the current one, indexed by column.
            logic [N-1:0] r_lb [KERNEL-1][IMG_W];

            always_ff @(posedge clk) begin
                if (pix_valid) begin
                    r_lb[0][w_col] <= pix_in;
                    for (int k = 1; k < KERNEL - 1; k++) begin
                        r_lb[k][w_col] <= r_lb[k-1][w_col];
                    end
                end
            end

            for (genvar k = 0; k < KERNEL - 1; k++) begin : g_tap
                assign w_new_col[KERNEL-2-k] = r_lb[k][w_col];
            end

            assign w_complete = (w_row >= c_ROW_FIRST) && (w_col >= c_COL_FIRST);
        end else begin : g_no_lb
            assign w_complete = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_eof       <= 1'b0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    r_win_arr[r][c] <= '0;
                end
            end
        end else begin
            r_win_valid <= pix_valid && w_complete;
            r_eof       <= pix_valid && (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
            if (pix_valid) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int c = 0; c < KERNEL - 1; c++) begin
                        r_win_arr[r][c] <= r_win_arr[r][c+1];
                    end
                    r_win_arr[r][KERNEL-1] <= w_new_col[r];
                end
            end
        end
    end

    // Slot r*KERNEL+c, top row first, matching the conv stage weight order.
    generate
        for (genvar r = 0; r < KERNEL; r++) begin : g_pack_row
            for (genvar c = 0; c < KERNEL; c++) begin : g_pack_col
                assign win[(r*KERNEL+c)*N +: N] = r_win_arr[r][c];
            end
        end
    endgenerate

    assign win_valid = r_win_valid;
    assign eof       = r_eof;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_gen
// Description : Scoreboard bench for conv_window_gen (K=3 and K=1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

    localparam int c_K  = 3;
    localparam int c_N  = 4;
    localparam int c_W  = 8;
    localparam int c_H  = 8;
    localparam int c_WB = c_K * c_K * c_N;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pix_valid = 1'b0;
    logic             sof = 1'b0;
    logic [c_N-1:0]   pix_in = '0;
    logic [c_WB-1:0]  win;
    logic             win_valid;
    logic             eof;
    logic [c_N-1:0]   win1;
    logic             win_valid1;
    logic             eof1;

    always #5 clk = ~clk;

    conv_window_gen #(.KERNEL(c_K), .N(c_N), .IMG_W(c_W), .IMG_H(c_H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win(win), .win_valid(win_valid), .eof(eof)
    );

    conv_window_gen #(.KERNEL(1), .N(c_N), .IMG_W(c_W), .IMG_H(c_H)) dut_k1 (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win(win1), .win_valid(win_valid1), .eof(eof1)
    );

    typedef struct {
        longint          stamp;
        logic [c_WB-1:0] win;
        logic            eof;
    } exp_t;

    exp_t            q3[$];
    exp_t            q1[$];
    exp_t            e3;
    exp_t            e1;
    int              checks = 0;
    int              errors = 0;
    longint          cyc = 0;
    logic            prev_v = 1'b0;
    logic            prev_rst = 1'b1;
    logic [c_WB-1:0] last_win = '0;
    logic [c_WB-1:0] first_win = '0;
    logic [c_WB-1:0] second_win = '0;
    logic [c_WB-1:0] final_win = '0;
    longint          first_stamp = 0;
    longint          second_stamp = 0;
    longint          start_stamp = 0;
    int              win_cnt = 0;
    int              eof_cnt = 0;
    int              win1_cnt = 0;
    int              eof1_cnt = 0;
    logic [c_N-1:0]  img [c_H][c_W];
    int              mrow = 0;
    int              mcol = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_v   <= pix_valid;
        prev_rst <= rst;
    end

    always @(negedge clk) begin
        if (prev_rst) begin
            check("rst_win", win, 0);
            check("rst_valid", win_valid, 0);
            check("rst_eof", eof, 0);
            check("rst_valid_k1", win_valid1, 0);
        end else if (!prev_v) begin
            check("bubble_valid", win_valid, 0);
            check("bubble_hold", win, last_win);
        end

        while (q3.size() > 0 && q3[0].stamp < cyc) begin
            check("missed_window", q3[0].stamp, cyc);
            void'(q3.pop_front());
        end
        if (win_valid) begin
            if (q3.size() == 0) begin
                check("spurious_window", win_valid, 0);
            end else begin
                e3 = q3.pop_front();
                check("win_time", cyc, e3.stamp);
                check("win", win, e3.win);
                check("eof", eof, e3.eof);
                if (win_cnt == 0) begin
                    first_win   = win;
                    first_stamp = cyc;
                end
                if (win_cnt == 36) begin
                    second_win   = win;
                    second_stamp = cyc;
                end
                final_win = win;
                win_cnt++;
            end
        end else begin
            check("eof_without_valid", eof, 0);
        end
        if (eof) eof_cnt++;

        while (q1.size() > 0 && q1[0].stamp < cyc) begin
            check("missed_window_k1", q1[0].stamp, cyc);
            void'(q1.pop_front());
        end
        if (win_valid1) begin
            if (q1.size() == 0) begin
                check("spurious_window_k1", win_valid1, 0);
            end else begin
                e1 = q1.pop_front();
                check("win_time_k1", cyc, e1.stamp);
                check("win_k1", win1, e1.win[c_N-1:0]);
                check("eof_k1", eof1, e1.eof);
                win1_cnt++;
            end
        end
        if (eof1) eof1_cnt++;

        last_win = win;
    end

    // Drive one cycle; the model places the pixel in a frame image and predicts windows.
    task automatic send(input logic v, input logic s, input logic [c_N-1:0] p);
        int   r;
        int   c;
        exp_t e;
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        if (v && !rst) begin
            r = s ? 0 : mrow;
            c = s ? 0 : mcol;
            img[r][c] = p;
            e.stamp = cyc + 1;
            e.eof   = (r == c_H - 1) && (c == c_W - 1);
            if (r >= c_K - 1 && c >= c_K - 1) begin
                e.win = '0;
                for (int wr = 0; wr < c_K; wr++) begin
                    for (int wc = 0; wc < c_K; wc++) begin
                        e.win[(wr*c_K+wc)*c_N +: c_N] = img[r-c_K+1+wr][c-c_K+1+wc];
                    end
                end
                q3.push_back(e);
            end
            e.win = '0;
            e.win[c_N-1:0] = p;
            q1.push_back(e);
            c++;
            if (c == c_W) begin
                c = 0;
                r = (r == c_H - 1) ? 0 : r + 1;
            end
            mrow = r;
            mcol = c;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, '0);
    endtask

    task automatic frame(input int tag, input bit first_sof, input int npix, input bit bubbles);
        int idx = 0;
        int slot = 0;
        while (idx < npix) begin
            if (bubbles && (slot % 3 == 2)) begin
                send(1'b0, 1'b0, '0);
            end else begin
                send(1'b1, first_sof && (idx == 0), c_N'((idx + tag) % 16));
                idx++;
            end
            slot++;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sof  = 1'b0;
        mrow = 0;
        mcol = 0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = (i % 2 == 0);
            pix_in    = c_N'(i + 3);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic clear_counts();
        win_cnt  = 0;
        eof_cnt  = 0;
        win1_cnt = 0;
        eof1_cnt = 0;
    endtask

    initial begin
        do_reset();

        clear_counts();
        start_stamp = cyc + 1;
        frame(0, 1'b1, 64, 1'b0);
        idle(2);
        check("cont_windows", win_cnt, 36);
        check("cont_eof", eof_cnt, 1);
        check("cont_first_win", first_win, 36'h210A98210);
        check("cont_first_latency", first_stamp - start_stamp, 18);
        check("cont_last_slot8", final_win[35:32], 15);
        check("k1_windows", win1_cnt, 64);
        check("k1_eof", eof1_cnt, 1);

        clear_counts();
        frame(0, 1'b1, 64, 1'b1);
        idle(2);
        check("bub_windows", win_cnt, 36);
        check("bub_eof", eof_cnt, 1);
        check("bub_first_win", first_win, 36'h210A98210);
        check("bub_last_slot8", final_win[35:32], 15);

        clear_counts();
        start_stamp = cyc + 1;
        frame(0, 1'b1, 64, 1'b0);
        frame(5, 1'b0, 64, 1'b0);
        idle(2);
        check("b2b_windows", win_cnt, 72);
        check("b2b_eof", eof_cnt, 2);
        check("b2b_second_latency", second_stamp - start_stamp, 82);
        check("b2b_second_first_win", second_win, 36'h765FED765);
        check("b2b_k1_windows", win1_cnt, 128);

        clear_counts();
        frame(0, 1'b1, 30, 1'b0);
        idle(1);
        check("sofabort_windows", win_cnt, 10);
        check("sofabort_eof", eof_cnt, 0);
        clear_counts();
        frame(5, 1'b1, 64, 1'b0);
        idle(2);
        check("sofresync_windows", win_cnt, 36);
        check("sofresync_eof", eof_cnt, 1);
        check("sofresync_k1_windows", win1_cnt, 64);

        clear_counts();
        frame(0, 1'b1, 30, 1'b0);
        do_reset();
        clear_counts();
        frame(5, 1'b0, 64, 1'b0);
        idle(2);
        check("rstresync_windows", win_cnt, 36);
        check("rstresync_eof", eof_cnt, 1);
        check("rstresync_k1_eof", eof1_cnt, 1);

        check("queue_empty", q3.size(), 0);
        check("queue_empty_k1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
